// File: rtl/ann_mem_pkg.sv
// Shared types and constants for the ANN weight memory read path.
package ann_mem_pkg;

    localparam int WEIGHT_DEPTH  = 28;
    localparam int WEIGHT_ADDR_W = 5;
    localparam int WEIGHT_DATA_W = 16;

    // Fetch controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } wfetch_state_t;

    // One buffered weight: the word, the address it came from, and whether
    // it is the final word of the pass.
    typedef struct packed {
        logic [WEIGHT_DATA_W-1:0] data;
        logic [WEIGHT_ADDR_W-1:0] index;
        logic                     last;
    } wfetch_entry_t;

endpackage

// File: rtl/wfetch_skid_fifo.sv
// Two-entry synchronous skid FIFO between the weight BRAM read port and the
// MAC. Entry 0 is always the head, so the head outputs come straight from a
// register. Push and pop in the same cycle are allowed; the caller never
// pushes into a full FIFO. Flush empties it in one cycle.
module wfetch_skid_fifo
    import ann_mem_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  wfetch_entry_t i_push_entry,
    input  logic          i_pop,
    output wfetch_entry_t o_head,
    output logic [1:0]    o_count
);

    wfetch_entry_t r_entry0;
    wfetch_entry_t r_entry1;
    logic [1:0]    r_count;
    logic          w_pop;

    // A pop of an empty FIFO is ignored.
    assign w_pop = i_pop && (r_count != 2'd0);

    // Entry storage and occupancy; reset and flush both empty the FIFO.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_count  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_entry0 <= i_push_entry;
                    end else begin
                        r_entry1 <= i_push_entry;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_entry0 <= r_entry1;
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_entry0 <= i_push_entry;
                    end else begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= i_push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_entry0;
    assign o_count = r_count;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Read-side controller for one per-neuron weight BRAM. On START it reads
// addresses 0..DEPTH-1 and streams the words to the MAC over valid/ready,
// buffering up to two words in a skid FIFO.
//
// Handshake: a beat transfers on every posedge where o_w_valid and i_w_ready
// are both high; while o_w_valid is high and i_w_ready is low the beat
// (data, index, last) is held unchanged; o_w_valid never drops without a
// transfer except on abort or reset.
//
// Optional feature: define WFETCH_STALL_CNT_EN to build the backpressure
// stall counter; otherwise o_stall_cnt is tied to zero.
module weight_fetch_ctrl
    import ann_mem_pkg::*;
#(
    parameter int DEPTH  = WEIGHT_DEPTH,
    parameter int ADDR_W = WEIGHT_ADDR_W,
    parameter int DATA_W = WEIGHT_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_en,
    output logic              o_bram_we,
    output logic [DATA_W-1:0] o_bram_di,
    input  logic [DATA_W-1:0] i_bram_do,
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_w_valid,
    input  logic              i_w_ready,
    output logic              o_w_last,
    output logic [ADDR_W-1:0] o_w_index,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_stall_cnt,
    output wfetch_state_t     o_state
);

    wfetch_state_t     r_state;
    wfetch_state_t     w_next_state;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_bram_addr;
    // High exactly on issue cycles; doubles as the BRAM read enable, and
    // marks that BRAM_DO must be captured on the next posedge.
    logic              r_inflight;
    logic              w_issue;
    logic              w_start_acc;
    logic              w_abort;
    logic              w_pop;
    logic              w_valid;
    logic [2:0]        w_occ;
    logic [1:0]        w_count;
    wfetch_entry_t     w_push_entry;
    wfetch_entry_t     w_head;

    assign w_abort = i_abort && (r_state != ST_IDLE);
    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid && i_w_ready;
    // Words that will be buffered after this edge; a new issue lands one
    // cycle later, so keeping this below 2 makes overflow impossible.
    assign w_occ   = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, issue decision and START acceptance; ABORT overrides all.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_start_acc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_next_state = ST_FETCH;
                    w_start_acc  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (w_occ < 3'd2) begin
                    w_issue = 1'b1;
                    if (r_rd_ptr == ADDR_W'(DEPTH - 1)) begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head.last) begin
                    w_next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next_state = ST_IDLE;
            w_issue      = 1'b0;
        end
    end

    // Read pointer, registered BRAM address and in-flight flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr    <= '0;
            r_bram_addr <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start_acc || w_abort) begin
                r_rd_ptr <= '0;
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_issue) begin
                r_bram_addr <= r_rd_ptr;
            end
        end
    end

    // The BRAM presents data by the posedge after the issue cycle; the
    // address register still holds the address it was read from.
    assign w_push_entry.data  = i_bram_do;
    assign w_push_entry.index = r_bram_addr;
    assign w_push_entry.last  = (r_bram_addr == ADDR_W'(DEPTH - 1));

    wfetch_skid_fifo u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (w_abort),
        .i_push       (r_inflight),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count)
    );

`ifdef WFETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles a valid beat waits on the MAC.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_start_acc) begin
            r_stall_cnt <= 16'd0;
        end else if (w_valid && !i_w_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = 16'd0;
`endif

    assign o_bram_addr = r_bram_addr;
    assign o_bram_en   = r_inflight;
    assign o_bram_we   = 1'b0;
    assign o_bram_di   = '0;
    assign o_w_data    = w_head.data;
    assign o_w_index   = w_head.index;
    assign o_w_last    = w_head.last;
    assign o_w_valid   = w_valid;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_FIN);
    assign o_state     = r_state;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: BRAM model, directed and
// randomized W_READY patterns, and a pass-level reference model checked on
// every cycle. Set WFETCH_STALL_CNT_EN to match the RTL build.
module tb_weight_fetch_ctrl;
  import ann_mem_pkg::*;

  localparam int DEPTH = 28;
`ifdef WFETCH_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  // clock / reset / dut signals
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic w_ready = 1'b0;
  logic [15:0] bram_do = 16'd0;
  logic [4:0] o_bram_addr;
  logic o_bram_en;
  logic o_bram_we;
  logic [15:0] o_bram_di;
  logic [15:0] o_w_data;
  logic o_w_valid;
  logic o_w_last;
  logic [4:0] o_w_index;
  logic o_busy;
  logic o_done;
  logic [15:0] o_stall_cnt;
  wfetch_state_t o_state;

  always #5 clk = ~clk;

  weight_fetch_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .o_bram_addr(o_bram_addr), .o_bram_en(o_bram_en), .o_bram_we(o_bram_we),
    .o_bram_di(o_bram_di), .i_bram_do(bram_do), .o_w_data(o_w_data),
    .o_w_valid(o_w_valid), .i_w_ready(w_ready), .o_w_last(o_w_last),
    .o_w_index(o_w_index), .o_busy(o_busy), .o_done(o_done),
    .o_stall_cnt(o_stall_cnt), .o_state(o_state)
  );

  // negedge-clocked weight BRAM, word = 0x0100 + addr
  logic [15:0] mem [0:31];
  initial for (int i = 0; i < 32; i++) mem[i] = 16'h0100 + 16'(i);
  always @(negedge clk) if (o_bram_en) bram_do <= mem[o_bram_addr];

  // scoreboard and pass-level model state
  int vectors = 0;
  int errors = 0;
  logic [21:0] exp_q[$];
  int cyc = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit prev_rst = 0;
  bit prev_stall = 0;
  logic [21:0] prev_beat = '0;
  logic [15:0] m_stall = '0;
  int m_issued = 0;
  int m_accepted = 0;
  int start_cyc = 0;
  int first_en_cyc = -1;
  int first_valid_cyc = -1;
  int last_beat_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  logic [15:0] first_data = '0;
  logic [15:0] last_data = '0;
  bit we_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // per-cycle compare against the pass-level model, sampled at negedge
  task automatic monitor();
    logic [21:0] beat;
    logic [21:0] e;
    bit pop;
    bit nd;
    cyc++;
    if (o_bram_we) we_seen = 1;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; exp_q.delete(); m_stall = '0;
      prev_stall = 0; m_issued = 0; m_accepted = 0; prev_rst = 1;
      return;
    end
    if (prev_rst) begin
      chk("rst_addr", o_bram_addr, 0);
      chk("rst_en", o_bram_en, 0);
      chk("rst_valid", o_w_valid, 0);
      chk("rst_last", o_w_last, 0);
      chk("rst_index", o_w_index, 0);
      chk("rst_data", o_w_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_stall", o_stall_cnt, 0);
      prev_rst = 0;
    end
    beat = {o_w_data, o_w_index, o_w_last};
    pop = o_w_valid && w_ready;
    chk("busy", o_busy, m_busy);
    chk("done", o_done, m_done);
    chk("bram_we", o_bram_we, 0);
    chk("bram_di", o_bram_di, 0);
    chk("stall_cnt", o_stall_cnt, STALL_EN ? m_stall : 16'd0);
    if (!m_busy) chk("valid_idle", o_w_valid, 0);
    if (prev_stall) begin
      chk("hold_valid", o_w_valid, 1);
      chk("hold_beat", beat, prev_beat);
    end
    if (o_bram_en) begin
      if (m_issued == 0) first_en_cyc = cyc;
      chk("en_addr", o_bram_addr, m_issued);
      chk("en_occupancy", (m_issued + 1 - m_accepted <= 2) ? 1 : 0, 1);
      m_issued++;
    end
    if (o_w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (o_done) begin done_cyc = cyc; done_cnt++; end
    if (pop) begin
      if (exp_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL extra_beat: got %h expected no beat", beat);
      end else begin
        e = exp_q.pop_front();
        chk("beat", beat, e);
      end
      if (m_accepted == 0) first_data = o_w_data;
      last_data = o_w_data;
      m_accepted++;
      if (o_w_last) last_beat_cyc = cyc;
    end
    prev_stall = o_w_valid && !w_ready;
    prev_beat = beat;
    if (o_w_valid && !w_ready && m_stall != 16'hFFFF) m_stall++;
    nd = 0;
    if (abort && m_busy) begin
      m_busy = 0; exp_q.delete();
    end else if (m_busy) begin
      if (m_done) m_busy = 0;
      if (pop && beat[0]) nd = 1;
    end else if (start && !abort) begin
      m_busy = 1; exp_q.delete();
      for (int i = 0; i < DEPTH; i++)
        exp_q.push_back({16'h0100 + 16'(i), 5'(i), (i == DEPTH - 1)});
      m_issued = 0; m_accepted = 0; m_stall = '0; start_cyc = cyc;
      first_en_cyc = -1; first_valid_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    end
    m_done = nd;
  endtask

  // driver: one cycle, inputs change 2 time units after posedge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1, 2: random
  task automatic run_pass(input int mode, input int budget);
    for (int k = 0; k < budget && m_busy; k++) begin
      case (mode)
        0: w_ready = 1;
        1: w_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
    end
    chk("pass_timeout", m_busy, 0);
    w_ready = 1;
  endtask

  initial begin
    int base;
    int k;
    @(posedge clk); #2;
    tick(); tick(); tick();
    rst_n = 1;
    tick();

    // full-rate pass with hand-computed latencies
    base = done_cnt;
    w_ready = 1;
    pulse_start();
    run_pass(0, 200);
    chk("lat_first_en", first_en_cyc - start_cyc, 2);
    chk("lat_first_valid", first_valid_cyc - start_cyc, 3);
    chk("lat_last_beat", last_beat_cyc - start_cyc, 30);
    chk("lat_done", done_cyc - start_cyc, 31);
    chk("first_data", first_data, 16'h0100);
    chk("last_data", last_data, 16'h011B);
    chk("beats_fullrate", m_accepted, 28);
    chk("done_count_fullrate", done_cnt - base, 1);
    tick();

    // ready 1,0,0,1 pattern
    base = done_cnt;
    pulse_start();
    run_pass(1, 400);
    chk("beats_pattern", m_accepted, 28);
    chk("done_count_pattern", done_cnt - base, 1);
    tick();

    // ready held low for 10 cycles after START
    w_ready = 0;
    pulse_start();
    w_ready = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("issues_while_blocked", m_issued, 2);
    chk("beats_while_blocked", m_accepted, 0);
    run_pass(0, 200);
    chk("beats_after_block", m_accepted, 28);
    tick();

    // ABORT after 5 beats, restart 3 cycles later
    base = done_cnt;
    w_ready = 1;
    pulse_start();
    k = 0;
    while (m_accepted < 5 && k < 100) begin tick(); k++; end
    chk("abort_wait_timeout", (k < 100) ? 1 : 0, 1);
    abort = 1;
    tick();
    abort = 0;
    tick(); tick();
    chk("abort_no_done", done_cnt - base, 0);
    chk("abort_idle", m_busy, 0);
    pulse_start();
    run_pass(0, 200);
    chk("beats_after_abort", m_accepted, 28);
    chk("done_count_abort", done_cnt - base, 1);
    tick();

    // reset mid-DRAIN
    base = done_cnt;
    w_ready = 1;
    pulse_start();
    k = 0;
    while (m_issued < DEPTH && k < 100) begin tick(); k++; end
    chk("drain_wait_timeout", (k < 100) ? 1 : 0, 1);
    w_ready = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    w_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("reset_no_done", done_cnt - base, 0);

    // START while busy and in the FIN cycle
    base = done_cnt;
    w_ready = 1;
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    pulse_start();
    k = 0;
    while (!m_done && k < 100) begin tick(); k++; end
    chk("fin_wait_timeout", (k < 100) ? 1 : 0, 1);
    pulse_start();
    for (int i = 0; i < 6; i++) tick();
    chk("single_done", done_cnt - base, 1);
    chk("idle_after_fin", m_busy, 0);

    // randomized backpressure
    for (int p = 0; p < 3; p++) begin
      base = done_cnt;
      pulse_start();
      run_pass(2, 600);
      chk("beats_random", m_accepted, 28);
      chk("done_count_random", done_cnt - base, 1);
      tick();
    end

    chk("bram_we_never", we_seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Read-side controller for one per-neuron weight BRAM (16-bit words, 28-deep, negedge-clocked, EN/WE/ADDR/DI/DO). It sits between the weight memory and the neuron MAC. On START it walks the memory from address 0 to DEPTH-1 and streams each weight out over a valid/ready interface, with a small skid FIFO to absorb MAC backpressure. It never writes the memory: WE and DI are driven to constant 0.

## Interface
- DEPTH, 28: number of weights read per pass (addresses 0..DEPTH-1).
- ADDR_W, 5: BRAM address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 16: weight word width (signed fixed point, passed through unmodified).
- CLK  in  1  single clock; all controller logic on posedge; the attached BRAM uses negedge of the same clock.
- RST_N  in  1  synchronous, active-low reset.
- START  in  1  one-cycle pulse; begins a pass when idle, ignored otherwise.
- ABORT  in  1  flushes the in-progress pass.
- BRAM_ADDR  out  ADDR_W  read address to the memory.
- BRAM_EN  out  1  read enable, high only on issue cycles.
- BRAM_WE  out  1  constant 0.
- BRAM_DI  out  DATA_W  constant 0.
- BRAM_DO  in  DATA_W  memory read data.
- W_DATA  out  DATA_W  weight to the MAC.
- W_VALID  out  1  W_DATA is valid.
- W_READY  in  1  MAC accepts the weight.
- W_LAST  out  1  the current beat is index DEPTH-1.
- W_INDEX  out  ADDR_W  address the current beat was read from.
- BUSY  out  1  high while a pass is in progress.
- DONE  out  1  one-cycle pulse after the last beat is accepted.
- STALL_CNT  out  16  backpressure cycle count (see Configuration).

## Operation
- States:
  - IDLE to FETCH on START.
  - FETCH to DRAIN after address DEPTH-1 is issued.
  - DRAIN to FIN when the last beat is accepted (W_VALID & W_READY & W_LAST).
  - FIN to IDLE unconditionally. DONE is high exactly in FIN.
- ABORT, in any state other than IDLE:
  - Next state is IDLE.
  - FIFO and in-flight flag are cleared.
  - No DONE pulse.
  - ABORT has priority over every other event in the same cycle.
- START is ignored while BUSY, including in the FIN cycle. START and ABORT in the same cycle while IDLE: ABORT wins and the block stays IDLE.
- Issue rule: in FETCH, assert BRAM_EN with BRAM_ADDR = rd_ptr when (fifo_count + inflight - pop) < 2, where pop = W_VALID & W_READY. rd_ptr increments on each issue.
- Capture rule: inflight is set on an issue cycle. On the following posedge, BRAM_DO is pushed into the FIFO together with its address and a last flag (address == DEPTH-1).
- FIFO: 2 entries. W_DATA, W_INDEX and W_LAST come from the head entry. Push and pop in the same cycle are legal. Overflow is impossible by the issue rule.
- BRAM_ADDR holds its last value when not issuing. BRAM_WE = 0 and BRAM_DI = 0 always.
- BUSY = (state != IDLE).

## Timing
- Reset values: state IDLE, rd_ptr 0, inflight 0, FIFO empty, BRAM_ADDR 0, BRAM_EN 0, W_VALID 0, W_LAST 0, W_INDEX 0, W_DATA 0, BUSY 0, DONE 0, STALL_CNT 0.
- Reset mid-pass behaves the same as ABORT and also clears STALL_CNT.
- Read latency: address registered at posedge k, BRAM samples it at negedge k+½, data captured at posedge k+1, so W_VALID rises at k+1.
- Latency from START at posedge s: BRAM_EN at s+1, first W_VALID at s+2.
- With W_READY held high: one beat per cycle, last beat at s+1+DEPTH, DONE at s+2+DEPTH.
- W_DATA, W_INDEX and W_LAST are stable while W_VALID is high and W_READY is low.
- DEPTH=1: a single beat with W_LAST=1.

## Configuration
- WFETCH_STALL_CNT_EN defined:
  - STALL_CNT increments on every cycle with W_VALID=1 and W_READY=0, saturating at 16'hFFFF.
  - Cleared on START acceptance and on reset.
  - Holds its value after DONE and after ABORT.
- Not defined: STALL_CNT is tied to 0 and no counter logic is synthesized.

## Structure
- Shared package ann_mem_pkg:
  - state enum (IDLE, FETCH, DRAIN, FIN).
  - WEIGHT_DEPTH = 28, WEIGHT_ADDR_W = 5, WEIGHT_DATA_W = 16.
  - FIFO entry struct {data, index, last}.
- One natural sub-module: wfetch_skid_fifo, a 2-entry synchronous FIFO with push, pop, count, head outputs and a flush input.

## Test plan
- Load the BRAM model with word = 16'h0100 + addr. Pulse START with W_READY=1 -> 28 beats with W_DATA 16'h0100..16'h011B on consecutive cycles, W_LAST only on 16'h011B, DONE exactly one cycle after the last beat, BUSY low the following cycle.
- W_READY toggling 1,0,0,1 repeatedly -> data order and values unchanged, no beat duplicated or lost, BRAM_EN never high with 2 words buffered or in flight, W_DATA stable during stalls; with WFETCH_STALL_CNT_EN, STALL_CNT equals the number of stalled valid cycles.
- W_READY=0 for 10 cycles after START -> exactly 2 issues, then BRAM_EN held low; after W_READY rises the stream resumes from address 2.
- ABORT after 5 accepted beats, then START 3 cycles later -> no DONE for the first pass; the second pass begins at address 0 and completes with all 28 beats.
- RST_N low for one cycle mid-DRAIN -> all outputs at their reset values on the next cycle; no DONE.
- START pulsed while BUSY and in the FIN cycle -> ignored; exactly one pass and one DONE; BRAM_WE is never asserted.
